cdc_handshake_src: RTL and testbench

Source-side controller for a 4-phase req/ack CDC transfer of a WIDTH-bit word. It accepts a word on a valid/ready interface, holds the word stable on `data_o`, and drives `req_o` into the destination domain's `cdc_sync_2ff`. It consumes the acknowledge that has already been brought back through a `cdc_sync_2ff` in this domain (`ack_sync_i`). A wait-state timeout flags a stuck handshake.

---
 rtl/cdc_handshake_src.sv | 93 +++++++++
 tb/tb_cdc_handshake_src.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdc_handshake_src.sv
// Source side of a 4-phase req/ack CDC word transfer.
// Holds the word on data_o while req/ack cycle completes; flags stuck waits.
module cdc_handshake_src #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic             clock,
  input  logic             arst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] data_o,
  output logic             req_o,
  input  logic             ack_sync_i,
  output logic             done,
  output logic             timeout_err,
  input  logic             err_clr
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);
  localparam logic TEN = (TIMEOUT > 0);

  state_t state;
  state_t state_nx;
  logic [CW-1:0] cnt;
  logic accept;
  logic stay;
  logic hit;

  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = REQ;
      REQ:  if (ack_sync_i) state_nx = DROP;
      DROP: if (!ack_sync_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE) && !ack_sync_i;
    accept   = in_valid && in_ready;
    stay     = (state != IDLE) && (state_nx == state);
    hit      = TEN && stay && (cnt == TMAX - CW'(1));
  end

  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      data_o <= '0;
      req_o  <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= (state == DROP) && !ack_sync_i;
      if (accept) begin
        data_o <= in_data;
        req_o  <= 1'b1;
      end else if ((state == REQ) && ack_sync_i) begin
        req_o  <= 1'b0;
      end
    end
  end

  // Wait-state counter restarts on every state change and saturates.
  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n) begin
      cnt <= '0;
    end else if (state_nx != state) begin
      cnt <= '0;
    end else if (stay && TEN && (cnt != TMAX)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Set beats clear when both land on the same edge.
  always_ff @(posedge clock or negedge arst_n) begin
    if (!arst_n)      timeout_err <= 1'b0;
    else if (hit)     timeout_err <= 1'b1;
    else if (err_clr) timeout_err <= 1'b0;
  end

endmodule

// File: tb/tb_cdc_handshake_src.sv
// Bench for cdc_handshake_src: vector table, scoreboard, corner sequences.
module tb_cdc_handshake_src;

  localparam int W  = 8;
  localparam int TO = 8;

  logic         clock = 1'b0;
  logic         arst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [W-1:0] data_o;
  logic         req_o;
  logic         ack_sync_i;
  logic         done;
  logic         timeout_err;
  logic         err_clr;

  cdc_handshake_src #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .clock(clock),
    .arst_n(arst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .data_o(data_o),
    .req_o(req_o),
    .ack_sync_i(ack_sync_i),
    .done(done),
    .timeout_err(timeout_err),
    .err_clr(err_clr)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  logic [W-1:0] sbq[$];

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         a;
    logic         push;
    logic         req;
    logic         rdy;
    logic         dn;
    logic [W-1:0] dat;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // Scoreboard: every done pulse must present the next expected word.
  always @(negedge clock) begin
    if (arst_n && done) begin
      n_done++;
      if (sbq.size() == 0) chk("done_unexpected", 32'(done), 32'd0);
      else chk("sb_data", 32'(data_o), 32'(sbq.pop_front()));
    end
  end

  task automatic handshake(input int rd, input int fd,
                           input logic [W-1:0] hold);
    int k;
    int d0;
    d0 = n_done;
    chk("hs_req_up", 32'(req_o), 32'd1);
    repeat (rd - 1) begin
      step;
      chk("hs_hold_req", 32'(data_o), 32'(hold));
    end
    ack_sync_i = 1'b1;
    k = 0;
    do begin
      step;
      k++;
      chk("hs_hold_ack", 32'(data_o), 32'(hold));
    end while (req_o && k < 20);
    chk("hs_req_drop", 32'(req_o), 32'd0);
    repeat (fd - 1) begin
      step;
      chk("hs_hold_drop", 32'(data_o), 32'(hold));
      chk("hs_no_early_done", 32'(done), 32'd0);
    end
    ack_sync_i = 1'b0;
    step;
    chk("hs_done", 32'(done), 32'd1);
    chk("hs_hold_done", 32'(data_o), 32'(hold));
    step;
    chk("hs_done_1cyc", 32'(done), 32'd0);
    chk("hs_one_done", 32'(n_done - d0), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    //        v     d      a     push  req   rdy   dn    dat
    tbl[0] = '{1'b1, 8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h5A};
    tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A};
    tbl[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h5A};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A};
    tbl[4] = '{1'b1, 8'h77, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A};
    tbl[5] = '{1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h77};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h77};

    arst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    ack_sync_i = 1'b0;
    err_clr = 1'b0;
    step;
    step;
    arst_n = 1'b1;
    step;
    chk("rst_req", 32'(req_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);

    // Table: instant-ack transfer, stale ack in IDLE, release.
    for (int i = 0; i < 8; i++) begin
      in_valid = tbl[i].v;
      in_data = tbl[i].d;
      ack_sync_i = tbl[i].a;
      if (tbl[i].push) sbq.push_back(tbl[i].d);
      step;
      chk($sformatf("vec%0d_req", i), 32'(req_o), 32'(tbl[i].req));
      chk($sformatf("vec%0d_rdy", i), 32'(in_ready), 32'(tbl[i].rdy));
      chk($sformatf("vec%0d_done", i), 32'(done), 32'(tbl[i].dn));
      chk($sformatf("vec%0d_data", i), 32'(data_o), 32'(tbl[i].dat));
    end
    in_valid = 1'b0;
    ack_sync_i = 1'b0;
    step;

    // Single transfer with 4-cycle ack latency each way.
    in_valid = 1'b1;
    in_data = 8'h3C;
    sbq.push_back(8'h3C);
    step;
    in_valid = 1'b0;
    in_data = 8'hFF;
    chk("single_data", 32'(data_o), 32'h3C);
    handshake(4, 4, 8'h3C);

    // Back-to-back with in_valid held; junk data while busy.
    in_valid = 1'b1;
    for (int w = 1; w <= 3; w++) begin
      in_data = W'(w);
      sbq.push_back(W'(w));
      step;
      chk("b2b_accept", 32'(req_o), 32'd1);
      chk("b2b_data", 32'(data_o), 32'(w));
      in_data = 8'hEE;
      ack_sync_i = 1'b1;
      step;
      chk("b2b_data_drop", 32'(data_o), 32'(w));
      ack_sync_i = 1'b0;
      step;
      chk("b2b_done", 32'(done), 32'd1);
      chk("b2b_ready", 32'(in_ready), 32'd1);
      chk("b2b_no_capture", 32'(data_o), 32'(w));
    end
    in_valid = 1'b0;
    step;
    chk("b2b_done_clear", 32'(done), 32'd0);

    // Timeout in REQ, then late completion and clear.
    in_valid = 1'b1;
    in_data = 8'h99;
    sbq.push_back(8'h99);
    step;
    in_valid = 1'b0;
    repeat (TO - 1) begin
      step;
      chk("to_not_yet", 32'(timeout_err), 32'd0);
    end
    step;
    chk("to_set", 32'(timeout_err), 32'd1);
    chk("to_req_held", 32'(req_o), 32'd1);
    repeat (3) step;
    chk("to_sat", 32'(timeout_err), 32'd1);
    ack_sync_i = 1'b1;
    step;
    chk("to_req_drop", 32'(req_o), 32'd0);
    ack_sync_i = 1'b0;
    step;
    chk("to_done", 32'(done), 32'd1);
    chk("to_sticky", 32'(timeout_err), 32'd1);
    step;
    chk("to_sticky2", 32'(timeout_err), 32'd1);
    err_clr = 1'b1;
    step;
    err_clr = 1'b0;
    chk("to_clear", 32'(timeout_err), 32'd0);

    // Clear lands on the same edge as the set.
    in_valid = 1'b1;
    in_data = 8'h42;
    sbq.push_back(8'h42);
    step;
    in_valid = 1'b0;
    repeat (TO - 1) step;
    chk("col_pre", 32'(timeout_err), 32'd0);
    err_clr = 1'b1;
    step;
    err_clr = 1'b0;
    chk("col_set_wins", 32'(timeout_err), 32'd1);
    ack_sync_i = 1'b1;
    step;
    ack_sync_i = 1'b0;
    step;
    chk("col_done", 32'(done), 32'd1);
    err_clr = 1'b1;
    step;
    err_clr = 1'b0;
    chk("col_clear", 32'(timeout_err), 32'd0);

    // Async reset mid-REQ with timeout already flagged; word abandoned.
    in_valid = 1'b1;
    in_data = 8'hA5;
    step;
    in_valid = 1'b0;
    chk("mid_data", 32'(data_o), 32'hA5);
    repeat (TO) step;
    chk("mid_terr", 32'(timeout_err), 32'd1);
    #2;
    arst_n = 1'b0;
    #1;
    chk("arst_req", 32'(req_o), 32'd0);
    chk("arst_data", 32'(data_o), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_terr", 32'(timeout_err), 32'd0);
    step;
    arst_n = 1'b1;
    step;
    chk("arst_ready", 32'(in_ready), 32'd1);
    chk("arst_req_after", 32'(req_o), 32'd0);

    chk("sb_empty", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
